// File: rtl/fan_temp_scheduler.sv
// Temperature-driven fan scheduler: periodic sampling, 4-tap average, hysteretic level, PWM.
// Build option FAN_FORCE_FULL_ON_FAULT_EN: force full speed while sensor fault is active.
`timescale 1ns/1ps
module fan_temp_scheduler #(
   parameter logic [11:0] SAMPLE_PERIOD = 12'd560,
   parameter logic [7:0]  T1            = 8'd24,
   parameter logic [7:0]  T2            = 8'd28,
   parameter logic [7:0]  T3            = 8'd32,
   parameter logic [7:0]  HYST          = 8'd2
) (
   input  logic       clk_200kHz,
   input  logic       rst,
   input  logic       enable,
   input  logic [7:0] temperature,
   output logic [7:0] avg_temp,
   output logic [1:0] fan_level,
   output logic [7:0] pwm_duty,
   output logic       fan_pwm,
   output logic       sample_valid,
   output logic       fault
);

`ifdef FAN_FORCE_FULL_ON_FAULT_EN
   localparam bit FORCE_ON_FAULT = 1'b1;
`else
   localparam bit FORCE_ON_FAULT = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_SAMPLE,
      S_AVERAGE,
      S_DECIDE
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [11:0] period_cnt;
   logic [7:0]  sbuf [4];
   logic        primed;
   logic [1:0]  invalid_cnt;
   logic [7:0]  pwm_cnt;
   logic [9:0]  sum;
   logic [7:0]  t_up;
   logic [7:0]  t_dn;
   logic [1:0]  level_nxt;
   logic        sample_ok;
   logic        period_done;

   assign sample_ok   = (temperature != 8'd0);
   assign period_done = (period_cnt == SAMPLE_PERIOD - 12'd1);
   assign sum = {2'b00, sbuf[0]} + {2'b00, sbuf[1]}
              + {2'b00, sbuf[2]} + {2'b00, sbuf[3]};

   always_ff @(posedge clk_200kHz) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!enable) begin
         state_nxt = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE:    state_nxt = S_WAIT;
            S_WAIT:    if (period_done) state_nxt = S_SAMPLE;
            S_SAMPLE:  state_nxt = sample_ok ? S_AVERAGE : S_WAIT;
            S_AVERAGE: state_nxt = S_DECIDE;
            S_DECIDE:  state_nxt = S_WAIT;
            default:   state_nxt = S_IDLE;
         endcase
      end
   end

   // Thresholds are all >= HYST, so t_dn never underflows.
   always_comb begin
      t_up = T3;
      t_dn = 8'd0;
      unique case (fan_level)
         2'd0: t_up = T1;
         2'd1: begin t_up = T2; t_dn = T1 - HYST; end
         2'd2: begin t_up = T3; t_dn = T2 - HYST; end
         default: t_dn = T3 - HYST;
      endcase
   end

   always_comb begin
      level_nxt = fan_level;
      unique case (1'b1)
         (fan_level != 2'd3) && (avg_temp >= t_up):
            level_nxt = fan_level + 2'd1;
         (fan_level != 2'd0) && (avg_temp < t_dn):
            level_nxt = fan_level - 2'd1;
         default: level_nxt = fan_level;
      endcase
   end

   always_ff @(posedge clk_200kHz) begin
      if (rst) begin
         period_cnt   <= 12'd0;
         primed       <= 1'b0;
         invalid_cnt  <= 2'd0;
         fault        <= 1'b0;
         avg_temp     <= 8'd0;
         fan_level    <= 2'd0;
         sample_valid <= 1'b0;
         for (int i = 0; i < 4; i++) sbuf[i] <= 8'd0;
      end else begin
         sample_valid <= 1'b0;
         if (!enable) begin
            period_cnt <= 12'd0;
            primed     <= 1'b0;
            fan_level  <= 2'd0;
         end else begin
            unique case (state)
               S_IDLE: period_cnt <= 12'd0;
               S_WAIT: period_cnt <= period_done ? 12'd0 : period_cnt + 12'd1;
               S_SAMPLE: begin
                  if (sample_ok) begin
                     invalid_cnt <= 2'd0;
                     fault       <= 1'b0;
                     primed      <= 1'b1;
                     if (!primed) begin
                        for (int i = 0; i < 4; i++) sbuf[i] <= temperature;
                     end else begin
                        for (int i = 3; i > 0; i--) sbuf[i] <= sbuf[i-1];
                        sbuf[0] <= temperature;
                     end
                  end else begin
                     if (invalid_cnt != 2'd3) invalid_cnt <= invalid_cnt + 2'd1;
                     if (invalid_cnt >= 2'd2) begin
                        fault <= 1'b1;
                        if (FORCE_ON_FAULT) fan_level <= 2'd3;
                     end
                  end
               end
               S_AVERAGE: avg_temp <= sum[9:2];
               S_DECIDE: begin
                  fan_level    <= level_nxt;
                  sample_valid <= 1'b1;
               end
               default: period_cnt <= 12'd0;
            endcase
         end
      end
   end

   always_comb begin
      pwm_duty = 8'd0;
      unique case (fan_level)
         2'd0: pwm_duty = 8'd0;
         2'd1: pwm_duty = 8'd85;
         2'd2: pwm_duty = 8'd170;
         default: pwm_duty = 8'd255;
      endcase
   end

   always_ff @(posedge clk_200kHz) begin
      if (rst) pwm_cnt <= 8'd0;
      else     pwm_cnt <= pwm_cnt + 8'd1;
   end

   // Full duty must be solid on, not 255/256.
   assign fan_pwm = (pwm_duty == 8'hFF) | (pwm_cnt < pwm_duty);

endmodule
